// File: rtl/multi_shifter_seq.sv
// Multi-mode WIDTH-bit shift register that executes a multi-position shift one bit per clock, using a start/busy/done handshake.
// Defining SHIFTER_CARRY_EN adds a carry output that holds the last bit shifted out.
module multi_shifter_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
`ifdef SHIFTER_CARRY_EN
  output logic             carry,
`endif
  output logic             dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  // Computes one shift step. Clear and load are not handled here.
  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] v, input logic [2:0] op);
    case (op)
      3'b010:  return {1'b0, v[WIDTH-1:1]};
      3'b011:  return {v[WIDTH-2:0], 1'b0};
      3'b100:  return {v[WIDTH-1], v[WIDTH-1:1]};
      3'b101:  return {v[WIDTH-1], v[WIDTH-3:0], 1'b0};
      3'b110:  return {v[0], v[WIDTH-1:1]};
      3'b111:  return {v[WIDTH-2:0], v[WIDTH-1]};
      default: return v;
    endcase
  endfunction

`ifdef SHIFTER_CARRY_EN
  logic carry_q, carry_d;

  // Returns the bit that leaves the shifted field. Arithmetic left keeps the sign bit, so it loses bit W-2.
  function automatic logic carry_f(input logic [WIDTH-1:0] v, input logic [2:0] op);
    case (op)
      3'b010, 3'b100, 3'b110: return v[0];
      3'b011, 3'b111:         return v[WIDTH-1];
      3'b101:                 return v[WIDTH-2];
      default:                return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    q_d     = q_q;
    done_d  = 1'b0;
`ifdef SHIFTER_CARRY_EN
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d = sel;
          if (sel == 3'b000 || sel == 3'b001) begin
            q_d    = (sel == 3'b001) ? din : '0;
            done_d = 1'b1;
`ifdef SHIFTER_CARRY_EN
            carry_d = 1'b0;
`endif
          end else if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            q_d = step_f(q_q, sel);
`ifdef SHIFTER_CARRY_EN
            carry_d = carry_f(q_q, sel);
`endif
            if (amt == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              rem_d   = amt - AMT_W'(1);
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        q_d   = step_f(q_q, sel_q);
        rem_d = rem_q - AMT_W'(1);
`ifdef SHIFTER_CARRY_EN
        carry_d = carry_f(q_q, sel_q);
`endif
        if (rem_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

`ifdef SHIFTER_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end
  assign carry = carry_q;
`endif

  assign q           = q_q;
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multi_shifter_seq.sv
// Directed testbench for multi_shifter_seq with WIDTH=8 and AMT_W=3.
// Inputs change on the falling clock edge, and outputs are checked on the next falling edge.
module tb_multi_shifter_seq;

  logic       clk, rst_n, start;
  logic [2:0] sel, amt;
  logic [7:0] din, q;
  logic       busy, done, dbg_state;
`ifdef SHIFTER_CARRY_EN
  logic       carry;
`endif
  int checks = 0;
  int errors = 0;

  multi_shifter_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .amt(amt), .din(din),
    .q(q), .busy(busy), .done(done),
`ifdef SHIFTER_CARRY_EN
    .carry(carry),
`endif
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one start pulse. The task returns at the falling edge that follows the accept edge.
  task automatic issue(input logic [2:0] s, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; sel = s; amt = a; din = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sel = '0; amt = '0; din = '0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    issue(3'b001, 3'd5, 8'hA5);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q: got %h expected %h", q, 8'hA5); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_flags: got done=%b busy=%b expected 1 0", done, busy); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL load_carry: got %b expected 0", carry); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_logical_right();
    issue(3'b010, 3'd3, 8'h00);
    checks++; if (q !== 8'h52 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lsr_step1: got q=%h busy=%b done=%b expected 52 1 0", q, busy, done); end
    @(negedge clk);
    checks++; if (q !== 8'h29 || busy !== 1'b1) begin errors++; $display("FAIL lsr_step2: got q=%h busy=%b expected 29 1", q, busy); end
    @(negedge clk);
    checks++; if (q !== 8'h14 || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL lsr_final: got q=%h busy=%b done=%b expected 14 0 1", q, busy, done); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL lsr_carry: got %b expected 1", carry); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lsr_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_arith_right();
    issue(3'b001, 3'd0, 8'h96);
    issue(3'b100, 3'd2, 8'h00);
    checks++; if (q !== 8'hCB || busy !== 1'b1) begin errors++; $display("FAIL asr_step1: got q=%h busy=%b expected cb 1", q, busy); end
    @(negedge clk);
    checks++; if (q !== 8'hE5 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL asr_final: got q=%h done=%b busy=%b expected e5 1 0", q, done, busy); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL asr_carry: got %b expected 1", carry); end
`endif
  endtask

  task automatic test_arith_left();
    int busy_cycles = 0;
    int guard = 0;
    issue(3'b001, 3'd0, 8'h81);
    issue(3'b101, 3'd7, 8'h00);
    while (done !== 1'b1 && guard < 20) begin
      if (busy === 1'b1) busy_cycles++;
      guard++;
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL asl_timeout: got done=%b after %0d cycles expected 1", done, guard); end
    checks++; if (busy_cycles != 6) begin errors++; $display("FAIL asl_busy_cycles: got %0d expected 6", busy_cycles); end
    checks++; if (q !== 8'h80) begin errors++; $display("FAIL asl_q: got %h expected %h", q, 8'h80); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL asl_carry: got %b expected 1", carry); end
`endif
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 3'd0, 8'h3C);
    issue(3'b111, 3'd4, 8'h00);
    checks++; if (q !== 8'h78) begin errors++; $display("FAIL rol_step1: got %h expected 78", q); end
    start = 1'b1; sel = 3'b000; amt = 3'd0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (q !== 8'hF0 || busy !== 1'b1) begin errors++; $display("FAIL rol_ignore_start: got q=%h busy=%b expected f0 1", q, busy); end
    @(negedge clk);
    checks++; if (q !== 8'hE1) begin errors++; $display("FAIL rol_step3: got %h expected e1", q); end
    @(negedge clk);
    checks++; if (q !== 8'hC3 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rol_final: got q=%h done=%b busy=%b expected c3 1 0", q, done, busy); end
    start = 1'b1; sel = 3'b001; din = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    checks++; if (q !== 8'h0F || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_load: got q=%h done=%b busy=%b expected 0f 1 0", q, done, busy); end
  endtask

  task automatic test_reset_abort();
    int late_done = 0;
    issue(3'b110, 3'd7, 8'h00);
    checks++; if (q !== 8'h87 || busy !== 1'b1) begin errors++; $display("FAIL ror_step1: got q=%h busy=%b expected 87 1", q, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_reset: got q=%h busy=%b done=%b expected 00 0 0", q, busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) late_done++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d cycles with done/busy expected 0", late_done); end
  endtask

  task automatic test_zero_amount();
    issue(3'b001, 3'd0, 8'h5A);
    issue(3'b010, 3'd0, 8'hFF);
    checks++; if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL amt0_q: got q=%h done=%b busy=%b expected 5a 1 0", q, done, busy); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL amt0_carry_after_load: got %b expected 0", carry); end
`endif
    issue(3'b001, 3'd0, 8'h01);
    issue(3'b110, 3'd1, 8'h00);
    checks++; if (q !== 8'h80 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL amt1_ror: got q=%h done=%b busy=%b expected 80 1 0", q, done, busy); end
    issue(3'b010, 3'd0, 8'h00);
    checks++; if (q !== 8'h80 || done !== 1'b1) begin errors++; $display("FAIL amt0_hold: got q=%h done=%b expected 80 1", q, done); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL amt0_carry_hold: got %b expected 1", carry); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_logical_right();
    test_arith_right();
    test_arith_left();
    test_back_to_back();
    test_reset_abort();
    test_zero_amount();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_shifter_seq.md
# multi_shifter_seq

Parametrised multi-mode shift register with a sequenced multi-bit shift. It generalises the 4-bit, one-step-per-clock multi-mode shifter to WIDTH bits. It adds a start/busy/done handshake so that a single command can shift by 0..2^AMT_W-1 positions, one bit per clock. It sits as a register-file-side datapath element driven by a controller FSM or by the lab-board switch/button front end.

## Interface

- WIDTH, 8, data width in bits; must be >= 3.
- AMT_W, 3, width of the shift-amount field; requires 2^AMT_W >= WIDTH.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only when busy=0.
- sel  in  3  operation code, sampled with start.
- amt  in  AMT_W  shift count, sampled with start; ignored for sel 000/001.
- din  in  WIDTH  load value for sel 001.
- q  out  WIDTH  register contents.
- busy  out  1  high while shifts remain after the current edge.
- done  out  1  one-cycle pulse after a command completes.
- carry  out  1  last bit shifted out; present only with SHIFTER_CARRY_EN.

## Operation

- Opcodes:
  - 000: clear, q <= 0.
  - 001: load, q <= din.
  - 010: logical right, {0, q[W-1:1]}.
  - 011: logical left, {q[W-2:0], 0}.
  - 100: arithmetic right, {q[W-1], q[W-1:1]}.
  - 101: arithmetic left with sign held, {q[W-1], q[W-3:0], 0}.
  - 110: cyclic right, {q[0], q[W-1:1]}.
  - 111: cyclic left, {q[W-2:0], q[W-1]}.
- States:
  - IDLE, busy=0.
  - SHIFT, busy=1.
- Remaining-count register rem, AMT_W bits.
- Accept: at a rising edge with start=1 and state IDLE:
  - sel and amt are latched.
  - The first action executes on that same edge.
- 000/001, or shift with amt=0:
  - Single action; a shift with amt=0 leaves q unchanged.
  - Stay IDLE; done=1 for the next cycle.
- Shift with amt=N>=1:
  - One step on the accept edge.
  - If N>1: rem <= N-1 and go to SHIFT.
  - In SHIFT: one step per edge, rem decrements.
  - On the edge where rem goes 1->0: return to IDLE and set done=1 for one cycle.
- Any amt value is legal; amt >= WIDTH is executed literally (for example, cyclic by WIDTH returns the original value).
- start while busy=1 is ignored; the latched sel/amt are not disturbed.
- start in the cycle where done=1 is accepted normally, giving back-to-back commands with no bubble.
- din, sel and amt changes while busy have no effect.

## Timing

- Reset values (async, immediate on rst_n low): q=0, busy=0, done=0, carry=0, state IDLE, rem=0.
- Reset mid-SHIFT aborts the command and no done pulse is issued. The first edge after rst_n rises may accept a new start.
- Latency:
  - Clear, load, or amt=0: q valid after the accept edge; done during the following cycle; busy never asserts.
  - amt=N: final q after accept edge + (N-1) edges; busy high for N-1 cycles; done in the cycle after the final update.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- SHIFTER_CARRY_EN defined: the carry port exists.
  - Each shift step loads carry with the bit that leaves the shifted field:
    - Right shifts: q[0].
    - Logical/cyclic left: q[W-1].
    - Arithmetic left: q[W-2].
  - Clear/load set carry=0.
  - amt=0 leaves carry unchanged.
- Not defined: no carry port or register; all other behaviour is identical.

## Test plan

All scenarios use WIDTH=8 and AMT_W=3.

- Load: start sel=001 din=8'hA5 -> q=8'hA5 after the accept edge; done high 1 cycle; busy stays 0; carry=0.
- Logical right: from q=8'hA5, start sel=010 amt=3.
  - q steps 52, 29, 14.
  - busy high 2 cycles, then done.
  - Final q=8'h14, carry=1.
- Arithmetic right: from q=8'h96, sel=100 amt=2 -> q=8'hE5, carry=1.
- Arithmetic left: from q=8'h81, sel=101 amt=7 -> q=8'h80, carry=1.
- Cyclic left, busy and back-to-back handling: from q=8'h3C, sel=111 amt=4 -> q=8'hC3.
  - A start with sel=000 pulsed while busy is ignored.
  - A start with sel=001 din=8'h0F in the done cycle is accepted, giving q=8'h0F on that edge.
- Reset and zero amount:
  - Assert rst_n low during a sel=110 amt=7 run -> q=0, busy=0, done=0 immediately; no done after release.
  - Then load 8'h5A and run sel=010 amt=0 -> q stays 8'h5A; done pulses; carry unchanged.
